// File: rtl/corelet_ctrl_if.sv
// Corelet-side bus of the convolution sequencer: SRAM read port, L0 strobes,
// MAC instruction and SFU controls, plus the L0/OFIFO status inputs.
interface corelet_ctrl_if #(
    parameter int addr_w = 11
);
    logic              xmem_cen;
    logic              xmem_wen;
    logic [addr_w-1:0] xmem_addr;
    logic              wr_l0;
    logic              rd_l0;
    logic              l0_full;
    logic              l0_ready;
    logic [1:0]        inst_w;
    logic              mode;
    logic              acc;
    logic              relu;
    logic              o_valid;

    // Handshake: a read issues in exactly the cycles where xmem_cen=0; the
    // controller lowers cen only while l0_ready=1 (and l0_full=0) in that same
    // cycle, so issue == request & ready. The L0 write strobe wr_l0 follows each
    // issue by one cycle. o_valid=1 means one OFIFO row is consumed that cycle.
    modport master (
        output xmem_cen, xmem_wen, xmem_addr, wr_l0, rd_l0,
        output inst_w, mode, acc, relu,
        input  l0_full, l0_ready, o_valid
    );

    modport slave (
        input  xmem_cen, xmem_wen, xmem_addr, wr_l0, rd_l0,
        input  inst_w, mode, acc, relu,
        output l0_full, l0_ready, o_valid
    );
endinterface

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: one convolution pass over all kernel positions.
// Optional CTRL_PERF_EN adds the stall_cnt performance counter output.
module corelet_ctrl #(
    parameter int row     = 4,
    parameter int col     = 4,
    parameter int len_kij = 9,
    parameter int len_nij = 16,
    parameter int addr_w  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    corelet_ctrl_if.master    bus,
    output logic [3:0]        kij,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
`ifdef CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, W_LOAD, W_KERN, A_LOAD, A_EXEC, DRAIN, NEXT, FIN
    } state_t;

    localparam int wd_limit = 4 * (len_nij + row + col);
    localparam int cnt_w    = $clog2(wd_limit + 1);

    localparam logic [cnt_w-1:0] one_c  = cnt_w'(1);
    localparam logic [cnt_w-1:0] col_c  = cnt_w'(col);
    localparam logic [cnt_w-1:0] nij_c  = cnt_w'(len_nij);
    localparam logic [cnt_w-1:0] kern_c = cnt_w'(2 * col + row);
    localparam logic [cnt_w-1:0] wd_c   = cnt_w'(wd_limit);
    localparam logic [3:0]       kij_last = 4'(len_kij - 1);
    localparam logic [addr_w-1:0] addr_one = addr_w'(1);

    state_t            state;
    logic [cnt_w-1:0]  cnt;
    logic [cnt_w-1:0]  wd;
    logic [addr_w-1:0] addr;
    logic              wr_q, rd_q, acc_q, relu_q;
    logic [1:0]        inst_q;

    logic              pending, can_issue, issue;
    logic [addr_w-1:0] next_w_base;

    // Issue is qualified by l0_ready in the same cycle so no address is ever lost.
    always_comb begin
        pending = 1'b0;
        if (state == W_LOAD) pending = (cnt < col_c);
        if (state == A_LOAD) pending = (cnt < nij_c);
        can_issue = bus.l0_ready & ~bus.l0_full;
        issue     = pending & can_issue;
    end

    assign next_w_base = addr_w'(len_nij) + addr_w'(kij + 4'd1) * addr_w'(col);

    assign bus.xmem_cen  = ~issue;
    assign bus.xmem_wen  = 1'b1;
    assign bus.xmem_addr = addr;
    assign bus.wr_l0     = wr_q;
    assign bus.rd_l0     = rd_q;
    assign bus.inst_w    = inst_q;
    assign bus.mode      = 1'b0;
    assign bus.acc       = acc_q;
    assign bus.relu      = relu_q;
    assign state_dbg     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wd     <= '0;
            addr   <= '0;
            kij    <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            inst_q <= 2'b00;
            acc_q  <= 1'b0;
            relu_q <= 1'b0;
        end else begin
            wr_q <= issue;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= W_LOAD;
                        busy  <= 1'b1;
                        kij   <= 4'd0;
                        cnt   <= '0;
                        addr  <= addr_w'(len_nij);
                    end
                end
                W_LOAD: begin
                    // The cnt==col cycle is the one carrying the final wr_l0.
                    if (cnt == col_c) begin
                        state <= W_KERN;
                        cnt   <= '0;
                    end else if (issue) begin
                        cnt  <= cnt + one_c;
                        addr <= addr + addr_one;
                    end
                end
                W_KERN: begin
                    cnt <= cnt + one_c;
                    if (cnt < col_c) begin
                        rd_q   <= 1'b1;
                        inst_q <= 2'b01;
                    end else begin
                        rd_q   <= 1'b0;
                        inst_q <= 2'b00;
                    end
                    if (cnt == kern_c) begin
                        state <= A_LOAD;
                        cnt   <= '0;
                        addr  <= '0;
                    end
                end
                A_LOAD: begin
                    if (cnt == nij_c) begin
                        state <= A_EXEC;
                        cnt   <= '0;
                    end else if (issue) begin
                        cnt  <= cnt + one_c;
                        addr <= addr + addr_one;
                    end
                end
                A_EXEC: begin
                    if (cnt == nij_c) begin
                        rd_q   <= 1'b0;
                        inst_q <= 2'b00;
                        state  <= DRAIN;
                        cnt    <= '0;
                        wd     <= '0;
                        acc_q  <= (kij != 4'd0);
                        relu_q <= (kij == kij_last);
                    end else begin
                        rd_q   <= 1'b1;
                        inst_q <= 2'b10;
                        cnt    <= cnt + one_c;
                    end
                end
                DRAIN: begin
                    wd <= wd + one_c;
                    if (bus.o_valid) cnt <= cnt + one_c;
                    // Leave on the last row, or when the watchdog window is used up.
                    if ((bus.o_valid && cnt == nij_c - one_c) || wd == wd_c - one_c) begin
                        state  <= NEXT;
                        acc_q  <= 1'b0;
                        relu_q <= 1'b0;
                    end
                end
                NEXT: begin
                    if (kij == kij_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        kij   <= kij + 4'd1;
                        state <= W_LOAD;
                        cnt   <= '0;
                        addr  <= next_w_base;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic stall_evt;
    assign stall_evt = (pending & ~can_issue) | ((state == DRAIN) & ~bus.o_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cnt <= 16'd0;
        end else if (stall_evt && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: pass-level table, kernel acc/relu table, reference
// address scoreboard, plus stall, watchdog, busy-start and mid-pass reset cases.
module tb_corelet_ctrl;

    localparam int row     = 4;
    localparam int col     = 4;
    localparam int len_kij = 9;
    localparam int len_nij = 16;
    localparam int addr_w  = 11;
    localparam int budget  = 5000;

    typedef struct {
        int rdy_pct;
        int vld_pct;
        bit start_mid;
        bit wd;
        bit stall7;
        int exp_drain;
        int exp_stall;
    } pass_t;

    typedef struct {
        int   k;
        logic exp_acc;
        logic exp_relu;
    } kvec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  kij;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;
`ifdef CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    corelet_ctrl_if #(.addr_w(addr_w)) bus ();

    corelet_ctrl #(
        .row(row), .col(col), .len_kij(len_kij), .len_nij(len_nij), .addr_w(addr_w)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .kij(kij),
        .busy(busy),
        .done(done),
        .state_dbg(state_dbg)
`ifdef CTRL_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    int n_vec = 0;
    int n_err = 0;
    logic [addr_w-1:0] exp_q[$];
    bit   mon_en = 1'b0;
    int   n_issue, n_wr, n_wr_a0, n_k, n_x, n_done, n_drain, iter;
    bit   prev_issue, prev_issue_a0, k1_started;
    logic [1:0] prev_inst;
    logic acc_seen [len_kij];
    logic relu_seen[len_kij];

    pass_t ptab[6];
    kvec_t ktab[len_kij];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_xmem_cen", bus.xmem_cen, 1);
        chk("rst_xmem_wen", bus.xmem_wen, 1);
        chk("rst_xmem_addr", bus.xmem_addr, 0);
        chk("rst_wr_l0", bus.wr_l0, 0);
        chk("rst_rd_l0", bus.rd_l0, 0);
        chk("rst_inst_w", bus.inst_w, 0);
        chk("rst_mode", bus.mode, 0);
        chk("rst_acc", bus.acc, 0);
        chk("rst_relu", bus.relu, 0);
        chk("rst_kij", kij, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state_idle", state_dbg, 0);
`ifdef CTRL_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
    endtask

    // Reference: every kernel position reads its col weights then all activations.
    task automatic build_model();
        exp_q.delete();
        for (int k = 0; k < len_kij; k++) begin
            for (int i = 0; i < col; i++) exp_q.push_back(addr_w'(len_nij + k * col + i));
            for (int n = 0; n < len_nij; n++) exp_q.push_back(addr_w'(n));
        end
        n_issue = 0; n_wr = 0; n_wr_a0 = 0; n_k = 0; n_x = 0;
        n_done = 0; n_drain = 0; iter = 0;
        prev_issue = 1'b0; prev_issue_a0 = 1'b0; k1_started = 1'b0;
        prev_inst = 2'b00;
        for (int k = 0; k < len_kij; k++) begin
            acc_seen[k] = 1'bx;
            relu_seen[k] = 1'bx;
        end
    endtask

    // monitor: sample on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            chk("xmem_wen_high", bus.xmem_wen, 1);
            chk("mode_zero", bus.mode, 0);
            chk("wr_l0_follows_issue", bus.wr_l0, prev_issue);
            chk("wr_rd_exclusive", bus.wr_l0 & bus.rd_l0, 0);
            chk("rd_with_inst", bus.rd_l0, bus.inst_w != 2'b00);
            chk("inst_legal", bus.inst_w == 2'b11, 0);
            if (!bus.xmem_cen) begin
                n_issue++;
                chk("issue_needs_ready", bus.l0_ready, 1);
                chk("busy_while_issuing", busy, 1);
                chk("scoreboard_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("xmem_addr", bus.xmem_addr, exp_q.pop_front());
                if (iter == 1 && bus.xmem_addr >= addr_w'(len_nij)) k1_started = 1'b1;
            end
            if (bus.wr_l0) begin
                n_wr++;
                if (prev_issue_a0) n_wr_a0++;
            end
            prev_issue    = !bus.xmem_cen;
            prev_issue_a0 = !bus.xmem_cen && bus.xmem_addr < addr_w'(len_nij) && iter == 0;
            if (bus.inst_w == 2'b01) n_k++;
            if (bus.inst_w == 2'b10) n_x++;
            if (prev_inst == 2'b10 && bus.inst_w != 2'b10) begin
                if (iter < len_kij) begin
                    acc_seen[iter]  = bus.acc;
                    relu_seen[iter] = bus.relu;
                    chk("kij_in_drain", kij, iter);
                end
                iter++;
            end
            prev_inst = bus.inst_w;
            if (state_dbg == 3'd5) n_drain++;
            if (done) begin
                n_done++;
                chk("busy_low_at_done", busy, 0);
            end
        end
    end

    // driver: one full pass, inputs changed 1 time unit after the rising edge
    task automatic run_pass(input pass_t p);
        int cyc;
        int stall_left;
        bit stalled;
        logic rdy, vld;
        build_model();
        mon_en = 1'b1;
        stall_left = 0;
        stalled = 1'b0;
        cyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        bus.l0_ready = 1'b1;
        bus.o_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n_done == 0 && cyc < budget) begin
            start = p.start_mid && (cyc == 50);
            rdy = ($urandom_range(99) < p.rdy_pct);
            vld = ($urandom_range(99) < p.vld_pct);
            if (p.wd && (iter == 0 || (iter == 1 && !k1_started))) vld = 1'b0;
            if (p.stall7 && !stalled && iter == 0 && bus.xmem_addr == addr_w'(7)) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) rdy = 1'b0;
            bus.l0_ready = rdy;
            bus.o_valid = vld;
            if (stall_left > 0) begin
                @(negedge clk);
                chk("stall_addr_hold", bus.xmem_addr, 7);
                chk("stall_cen_high", bus.xmem_cen, 1);
                chk("stall_busy", busy, 1);
                if (stall_left < 3) chk("stall_no_wr_l0", bus.wr_l0, 0);
                stall_left--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("pass_within_budget", cyc < budget, 1);
        if (p.stall7) chk("stall_applied", stalled, 1);
        bus.l0_ready = 1'b1;
        bus.o_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("done_once", n_done, 1);
        chk("busy_after", busy, 0);
        chk("idle_after", state_dbg, 0);
        chk("iterations", iter, len_kij);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("issue_count", n_issue, len_kij * (col + len_nij));
        chk("wr_l0_count", n_wr, len_kij * (col + len_nij));
        chk("a_load_wr_kij0", n_wr_a0, len_nij);
        chk("kernel_load_cycles", n_k, len_kij * col);
        chk("execute_cycles", n_x, len_kij * len_nij);
        for (int k = 0; k < len_kij; k++) begin
            chk("acc_per_kij", acc_seen[ktab[k].k], ktab[k].exp_acc);
            chk("relu_per_kij", relu_seen[ktab[k].k], ktab[k].exp_relu);
        end
        if (p.exp_drain >= 0) chk("drain_cycles", n_drain, p.exp_drain);
`ifdef CTRL_PERF_EN
        if (p.exp_stall >= 0) chk("stall_cnt", stall_cnt, p.exp_stall);
`endif
    endtask

    initial begin
        int cyc;
        pass_t plain;
        reset = 1'b1;
        start = 1'b0;
        bus.l0_ready = 1'b0;
        bus.l0_full = 1'b0;
        bus.o_valid = 1'b0;

        // rdy%, vld%, start_mid, watchdog, stall@7, drain cycles, stall_cnt
        ptab[0] = '{100, 100, 1'b1, 1'b0, 1'b0, len_kij * len_nij, 0};
        ptab[1] = '{100, 100, 1'b0, 1'b1, 1'b0, 96 + (len_kij - 1) * len_nij, 96};
        ptab[2] = '{100, 100, 1'b0, 1'b0, 1'b1, len_kij * len_nij, 3};
        ptab[3] = '{70, 60, 1'b0, 1'b0, 1'b0, -1, -1};
        ptab[4] = '{50, 80, 1'b1, 1'b0, 1'b0, -1, -1};
        ptab[5] = '{85, 40, 1'b0, 1'b0, 1'b0, -1, -1};
        for (int k = 0; k < len_kij; k++) ktab[k] = '{k, (k != 0), (k == len_kij - 1)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset();

        for (int i = 0; i < 6; i++) run_pass(ptab[i]);

        // reset in the middle of kernel 3 weight load, then a clean pass
        @(posedge clk); #1;
        start = 1'b1;
        bus.l0_ready = 1'b1;
        bus.o_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(kij == 4'd3 && bus.xmem_addr == addr_w'(len_nij + 3 * col + 1)) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_point_kij", kij, 3);
        reset = 1'b1;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset();
        plain = '{100, 100, 1'b0, 1'b0, 1'b0, len_kij * len_nij, 0};
        run_pass(plain);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Sequencer directly upstream of the corelet; drives every corelet control input.
- Runs one full convolution pass over all kernel positions: fetches weights and activations from the shared activation/weight SRAM into L0, issues kernel-load then execute instructions to the MAC array, and drains the OFIFO through the SFU.
- Started by a single start pulse from the top-level testbench/host; reports busy/done.

Parameters:
- row, 4, MAC array rows (L0 lanes)
- col, 4, MAC array columns
- len_kij, 9, kernel positions per pass
- len_nij, 16, activation vectors per kernel position
- addr_w, 11, SRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  one-cycle pulse; begins a pass when IDLE
- xmem_cen  out  1  SRAM chip enable, active-low
- xmem_wen  out  1  SRAM write enable, active-low; held 1 (read only)
- xmem_addr  out  addr_w  SRAM read address
- wr_l0  out  1  L0 write strobe
- rd_l0  out  1  L0 read strobe
- l0_full  in  1  L0 full
- l0_ready  in  1  L0 has room
- inst_w  out  2  MAC instruction: 01 kernel load, 10 execute, 00 idle
- mode  out  1  tied 0 (weight-stationary)
- acc  out  1  SFU accumulate-with-psum enable
- relu  out  1  SFU ReLU enable
- o_valid  in  1  OFIFO holds a readable row
- kij  out  4  current kernel index (debug)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at pass end

Behaviour:
- One clock domain; all state flops async-reset on reset=1.
- Reset values: xmem_cen=1, xmem_wen=1, xmem_addr=0, wr_l0=0, rd_l0=0, inst_w=00, mode=0, acc=0, relu=0, kij=0, busy=0, done=0; FSM=IDLE.
- FSM states: IDLE, W_LOAD, W_KERN, A_LOAD, A_EXEC, DRAIN, NEXT, FIN.
- IDLE: start=1 -> W_LOAD, busy=1, kij=0. start is ignored in any other state.
- SRAM read latency is 1 cycle. An address is issued (cen=0) only when l0_ready=1. wr_l0 is the issue strobe delayed 1 cycle. Counters advance only on issue; on l0_ready=0 the address holds, with no skip and no duplicate.
- W_LOAD: issue col addresses len_nij+kij*col+i, i=0..col-1. After the last issue wait 1 cycle for the final wr_l0, then go to W_KERN.
- W_KERN: rd_l0=1, inst_w=01 for col cycles, then inst_w=00 for row+col idle cycles (flush), then A_LOAD.
- A_LOAD: issue addresses 0..len_nij-1, same rules as W_LOAD; then A_EXEC.
- A_EXEC: rd_l0=1, inst_w=10 for exactly len_nij cycles; then DRAIN.
- DRAIN:
  - acc = (kij!=0); relu = (kij==len_kij-1).
  - Count OFIFO rows consumed, i.e. cycles with o_valid=1.
  - After len_nij rows -> NEXT.
  - Watchdog: after 4*(len_nij+row+col) cycles without completion, force NEXT.
- NEXT: if kij==len_kij-1 -> FIN, else kij+1 -> W_LOAD.
- FIN: done=1 for one cycle, busy=0, acc=relu=0 -> IDLE.
- wr_l0 and rd_l0 are never asserted in the same cycle. inst_w=00 in every state except W_KERN (first col cycles) and A_EXEC.
- Address arithmetic is modulo 2^addr_w; overflow wraps silently. Defaults top out at 16+8*4+3=51.
- Reset mid-pass: immediate return to IDLE with reset values. No partial resume.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined: adds output stall_cnt [15:0]. It counts cycles in W_LOAD/A_LOAD where an issue was blocked by l0_ready=0, and cycles in DRAIN with o_valid=0. Cleared on start accept, saturates at 16'hFFFF, resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- reset mid-W_LOAD (kij=3) -> next cycle all outputs at reset values, FSM IDLE; following start begins at kij=0, addr 16.
- start, l0_ready=1, o_valid=1 always -> addresses 16..19 then 0..15; 4 inst_w=01 cycles, 16 inst_w=10 cycles; pass ends with 9 kernel iterations and done pulse exactly once; busy low after.
- l0_ready=0 for 3 cycles mid-A_LOAD at addr 7 -> addr holds 7, no wr_l0 during stall, 16 total wr_l0 pulses for that phase.
- kij=0 drain -> acc=0, relu=0; kij=1..7 -> acc=1, relu=0; kij=8 -> acc=1, relu=1.
- o_valid stuck 0 in DRAIN -> watchdog exits after 96 cycles, proceeds to NEXT; with CTRL_PERF_EN stall_cnt increases by 96.
- start pulse while busy -> ignored; done count stays 1 per pass.
